// File: rtl/ctrl_fsm_if.sv
// rtl/ctrl_fsm_if.sv - opcode/flag inputs and control strobes of the picoMIPS sequencer
interface ctrl_fsm_if #(
    parameter int OPW    = 6,
    parameter int FUNCW  = 3,
    parameter int NFLAGS = 4
);
    logic [OPW-1:0]    opcode;
    logic [NFLAGS-1:0] alu_flags;
    logic              in_valid;

    logic              PCincr;
    logic              PCabsbranch;
    logic              PCrelbranch;
    logic [FUNCW-1:0]  ALUfunc;
    logic              imm;
    logic              w;
    logic              ld;
    logic              in_ready;
    logic              stall;
    logic [NFLAGS-1:0] flags_q;
    logic              halted;
    logic              illegal_op;

    modport master (
        output opcode, alu_flags, in_valid,
        input  PCincr, PCabsbranch, PCrelbranch, ALUfunc, imm, w, ld,
               in_ready, stall, flags_q, halted, illegal_op
    );

    modport slave (
        input  opcode, alu_flags, in_valid,
        output PCincr, PCabsbranch, PCrelbranch, ALUfunc, imm, w, ld,
               in_ready, stall, flags_q, halted, illegal_op
    );
endinterface

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - stateful picoMIPS decoder: flags, multi-cycle LOAD, IN handshake, HALT
module ctrl_fsm #(
    parameter int             OPW     = 6,
    parameter int             FUNCW   = 3,
    parameter int             NFLAGS  = 4,
    parameter int             LD_LAT  = 2,
    parameter logic [OPW-1:0] HALT_OP = 6'h3F
) (
    input  logic     clk,
    input  logic     reset,
    ctrl_fsm_if.slave bus
);
    localparam logic [OPW-1:0] OP_NOP   = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(6'h03);
    localparam logic [OPW-1:0] OP_MULTI = OPW'(6'h06);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'h0A);
    localparam logic [OPW-1:0] OP_SUBI  = OPW'(6'h0B);
    localparam logic [OPW-1:0] OP_JUMP  = OPW'(6'h10);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'h11);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'h12);
    localparam logic [OPW-1:0] OP_BGE   = OPW'(6'h13);
    localparam logic [OPW-1:0] OP_BLO   = OPW'(6'h14);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(6'h19);
    localparam logic [OPW-1:0] OP_IN    = OPW'(6'h20);

    localparam logic [FUNCW-1:0] ALU_RB = FUNCW'(1);

    localparam int FC = 0;
    localparam int FZ = 1;
    localparam int FN = 2;

    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_RUN,
        S_LDWAIT,
        S_INWAIT,
        S_HALT
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [FUNCW-1:0]  func_q, func_nx;
    logic [NFLAGS-1:0] flags_r, flags_nx;
    logic              ill_r, ill_nx;

    logic              pc_inc, pc_abs, pc_rel;
    logic [FUNCW-1:0]  alu;
    logic              imm_s, w_s, ld_s, inr_s, stall_s;
    logic              taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_RUN;
            cnt     <= '0;
            func_q  <= '0;
            flags_r <= '0;
            ill_r   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            func_q  <= func_nx;
            flags_r <= flags_nx;
            ill_r   <= ill_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        func_nx  = func_q;
        flags_nx = flags_r;
        ill_nx   = ill_r;
        pc_inc   = 1'b0;
        pc_abs   = 1'b0;
        pc_rel   = 1'b0;
        alu      = bus.opcode[FUNCW-1:0];
        imm_s    = 1'b0;
        w_s      = 1'b0;
        ld_s     = 1'b0;
        inr_s    = 1'b0;
        stall_s  = 1'b0;
        taken    = 1'b0;

        // Reset forces every strobe low even though the state register is already RUN.
        if (!reset) begin
            case (state)
                S_RUN: begin
                    pc_inc = 1'b1;
                    if (bus.opcode == HALT_OP) begin
                        pc_inc   = 1'b0;
                        state_nx = S_HALT;
                    end else begin
                        case (bus.opcode)
                            OP_NOP: begin
                            end
                            OP_ADD, OP_SUB, OP_MULTI: begin
                                w_s      = 1'b1;
                                flags_nx = bus.alu_flags;
                            end
                            OP_ADDI, OP_SUBI: begin
                                w_s      = 1'b1;
                                imm_s    = 1'b1;
                                flags_nx = bus.alu_flags;
                            end
                            OP_JUMP: begin
                                pc_inc = 1'b0;
                                pc_abs = 1'b1;
                            end
                            OP_BEQ: taken = flags_r[FZ];
                            OP_BNE: taken = !flags_r[FZ];
                            OP_BGE: taken = !flags_r[FN];
                            OP_BLO: taken = flags_r[FC];
                            OP_LOAD: begin
                                ld_s = 1'b1;
                                if (LD_LAT == 0) begin
                                    w_s = 1'b1;
                                end else begin
                                    pc_inc   = 1'b0;
                                    stall_s  = 1'b1;
                                    cnt_nx   = CW'(LD_LAT - 1);
                                    func_nx  = bus.opcode[FUNCW-1:0];
                                    state_nx = S_LDWAIT;
                                end
                            end
                            OP_IN: begin
                                inr_s = 1'b1;
                                alu   = ALU_RB;
                                if (bus.in_valid) begin
                                    w_s = 1'b1;
                                end else begin
                                    pc_inc   = 1'b0;
                                    stall_s  = 1'b1;
                                    func_nx  = ALU_RB;
                                    state_nx = S_INWAIT;
                                end
                            end
                            default: ill_nx = 1'b1;
                        endcase
                        if (taken) begin
                            pc_inc = 1'b0;
                            pc_rel = 1'b1;
                        end
                    end
                end

                S_LDWAIT: begin
                    ld_s = 1'b1;
                    alu  = func_q;
                    if (cnt == '0) begin
                        w_s      = 1'b1;
                        pc_inc   = 1'b1;
                        state_nx = S_RUN;
                    end else begin
                        stall_s = 1'b1;
                        cnt_nx  = cnt - 1'b1;
                    end
                end

                S_INWAIT: begin
                    inr_s = 1'b1;
                    alu   = func_q;
                    if (bus.in_valid) begin
                        w_s      = 1'b1;
                        pc_inc   = 1'b1;
                        state_nx = S_RUN;
                    end else begin
                        stall_s = 1'b1;
                    end
                end

                S_HALT: begin
                end

                default: state_nx = S_RUN;
            endcase
        end
    end

    assign bus.PCincr      = pc_inc;
    assign bus.PCabsbranch = pc_abs;
    assign bus.PCrelbranch = pc_rel;
    assign bus.ALUfunc     = alu;
    assign bus.imm         = imm_s;
    assign bus.w           = w_s;
    assign bus.ld          = ld_s;
    assign bus.in_ready    = inr_s;
    assign bus.stall       = stall_s;
    assign bus.flags_q     = flags_r;
    assign bus.halted      = (state == S_HALT);
    assign bus.illegal_op  = ill_r;
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - scoreboard bench for ctrl_fsm at LD_LAT 0, 2 and 3
module tb_ctrl_fsm;
    localparam int NI = 3;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_ADD   = 6'h02;
    localparam logic [5:0] OP_SUB   = 6'h03;
    localparam logic [5:0] OP_MULTI = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h0A;
    localparam logic [5:0] OP_SUBI  = 6'h0B;
    localparam logic [5:0] OP_JUMP  = 6'h10;
    localparam logic [5:0] OP_BEQ   = 6'h11;
    localparam logic [5:0] OP_BNE   = 6'h12;
    localparam logic [5:0] OP_BGE   = 6'h13;
    localparam logic [5:0] OP_BLO   = 6'h14;
    localparam logic [5:0] OP_LOAD  = 6'h19;
    localparam logic [5:0] OP_IN    = 6'h20;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [2:0] ALU_RB   = 3'b001;

    typedef struct {
        bit         halt;
        bit         ill;
        logic [3:0] flags;
        bit         busy;
        int         j;
    } mst_t;

    typedef struct {
        logic [5:0] op;
        logic [3:0] fl;
        int         nw;
    } instr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opc  [NI];
    logic [3:0] afl  [NI];
    logic       inv  [NI];
    int         icnt [NI];
    int         pidx [NI];
    mst_t       ms   [NI];
    mst_t       nxt  [NI];
    logic [16:0] got [NI];
    logic [16:0] expq [NI][$];
    instr_t     prog [$];
    bit         rnd_mode;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    ctrl_fsm_if #(.OPW(6), .FUNCW(3), .NFLAGS(4)) if0 ();
    ctrl_fsm_if #(.OPW(6), .FUNCW(3), .NFLAGS(4)) if1 ();
    ctrl_fsm_if #(.OPW(6), .FUNCW(3), .NFLAGS(4)) if2 ();

    assign if0.opcode = opc[0]; assign if0.alu_flags = afl[0]; assign if0.in_valid = inv[0];
    assign if1.opcode = opc[1]; assign if1.alu_flags = afl[1]; assign if1.in_valid = inv[1];
    assign if2.opcode = opc[2]; assign if2.alu_flags = afl[2]; assign if2.in_valid = inv[2];

    assign got[0] = {if0.PCincr, if0.PCabsbranch, if0.PCrelbranch, if0.ALUfunc, if0.imm, if0.w, if0.ld,
                     if0.in_ready, if0.stall, if0.flags_q, if0.halted, if0.illegal_op};
    assign got[1] = {if1.PCincr, if1.PCabsbranch, if1.PCrelbranch, if1.ALUfunc, if1.imm, if1.w, if1.ld,
                     if1.in_ready, if1.stall, if1.flags_q, if1.halted, if1.illegal_op};
    assign got[2] = {if2.PCincr, if2.PCabsbranch, if2.PCrelbranch, if2.ALUfunc, if2.imm, if2.w, if2.ld,
                     if2.in_ready, if2.stall, if2.flags_q, if2.halted, if2.illegal_op};

    ctrl_fsm #(.LD_LAT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    ctrl_fsm #(.LD_LAT(2)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    ctrl_fsm #(.LD_LAT(3)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    function automatic mst_t rst_state();
        mst_t s;
        s.halt = 1'b0; s.ill = 1'b0; s.flags = 4'h0; s.busy = 1'b0; s.j = 0;
        return s;
    endfunction

    function automatic logic [5:0] legal_op(input int k);
        case (k)
            0: return OP_NOP;   1: return OP_ADD;   2: return OP_SUB;   3: return OP_MULTI;
            4: return OP_ADDI;  5: return OP_SUBI;  6: return OP_JUMP;  7: return OP_BEQ;
            8: return OP_BNE;   9: return OP_BGE;   10: return OP_BLO;  11: return OP_LOAD;
            default: return OP_IN;
        endcase
    endfunction

    function automatic instr_t mk(input logic [5:0] op, input logic [3:0] fl, input int nw);
        instr_t t;
        t.op = op; t.fl = fl; t.nw = nw;
        return t;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t t;
        int r;
        r = int'($urandom_range(0, 999));
        if (r < 3)        t.op = OP_HALT;
        else if (r < 100) t.op = 6'($urandom_range(0, 62));
        else              t.op = legal_op(int'($urandom_range(0, 12)));
        t.fl = 4'($urandom);
        t.nw = int'($urandom_range(0, 3));
        return t;
    endfunction

    // Flags are {V,N,Z,C}; a branch looks only at the registered flags.
    function automatic bit br_taken(input logic [5:0] op, input logic [3:0] f);
        case (op)
            OP_BEQ:  return f[1];
            OP_BNE:  return !f[1];
            OP_BGE:  return !f[2];
            default: return f[0];
        endcase
    endfunction

    // Instruction-level model: j counts cycles already spent on the current LOAD.
    function automatic void model(input int lat, input mst_t s, input logic [5:0] op,
                                  input logic [3:0] fin, input logic iv,
                                  output logic [16:0] o, output mst_t n);
        logic pi, pa, pr, im, wr, rd, ir, st;
        logic [2:0] af;
        n = s;
        pi = 1'b0; pa = 1'b0; pr = 1'b0; im = 1'b0; wr = 1'b0; rd = 1'b0; ir = 1'b0; st = 1'b0;
        af = op[2:0];
        if (s.halt) begin
        end else if (op == OP_HALT) begin
            n.halt = 1'b1;
        end else begin
            pi = 1'b1;
            case (op)
                OP_NOP: begin end
                OP_ADD, OP_SUB, OP_MULTI: begin wr = 1'b1; n.flags = fin; end
                OP_ADDI, OP_SUBI: begin wr = 1'b1; im = 1'b1; n.flags = fin; end
                OP_JUMP: begin pi = 1'b0; pa = 1'b1; end
                OP_BEQ, OP_BNE, OP_BGE, OP_BLO:
                    if (br_taken(op, s.flags)) begin pi = 1'b0; pr = 1'b1; end
                OP_LOAD: begin
                    rd = 1'b1;
                    if (s.j >= lat) begin wr = 1'b1; n.busy = 1'b0; n.j = 0; end
                    else begin pi = 1'b0; st = 1'b1; n.busy = 1'b1; n.j = s.j + 1; end
                end
                OP_IN: begin
                    ir = 1'b1;
                    af = ALU_RB;
                    if (iv) begin wr = 1'b1; n.busy = 1'b0; end
                    else begin pi = 1'b0; st = 1'b1; n.busy = 1'b1; end
                end
                default: n.ill = 1'b1;
            endcase
        end
        o = {pi, pa, pr, af, im, wr, rd, ir, st, s.flags, s.halt, s.ill};
    endfunction

    task automatic fetch(input int i);
        instr_t t;
        if (pidx[i] < prog.size()) begin
            t = prog[pidx[i]];
            pidx[i]++;
        end else if (rnd_mode) begin
            t = rnd_instr();
        end else begin
            t = mk(OP_NOP, 4'h0, 0);
        end
        opc[i] = t.op; afl[i] = t.fl; icnt[i] = t.nw;
    endtask

    task automatic step(input bit r);
        logic [16:0] o;
        mst_t n;
        @(posedge clk);
        #1;
        reset = r;
        for (int i = 0; i < NI; i++) begin
            ms[i] = nxt[i];
            if (!r && !ms[i].busy) fetch(i);
            if (opc[i] == OP_IN) begin
                inv[i] = (icnt[i] == 0);
                if (icnt[i] > 0) icnt[i]--;
            end else begin
                inv[i] = 1'($urandom);
            end
            if (r) begin
                o = {3'b000, opc[i][2:0], 5'b00000, 4'h0, 2'b00};
                n = rst_state();
            end else begin
                model(lat_of(i), ms[i], opc[i], afl[i], inv[i], o, n);
            end
            nxt[i] = n;
            expq[i].push_back(o);
        end
    endtask

    task automatic drain();
        bit done;
        for (int k = 0; k < 400; k++) begin
            done = 1'b1;
            for (int i = 0; i < NI; i++)
                if (pidx[i] < prog.size() || nxt[i].busy) done = 1'b0;
            if (done) break;
            step(1'b0);
        end
        repeat (3) step(1'b0);
    endtask

    task automatic new_prog();
        prog.delete();
        for (int i = 0; i < NI; i++) pidx[i] = 0;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (expq[i].size() > 0) begin
                logic [16:0] e;
                e = expq[i].pop_front();
                tests++;
                if (got[i] !== e) begin
                    fails++;
                    $display("FAIL dut%0d outputs t=%0t got=%h required=%h", i, $time, got[i], e);
                end
                tests++;
                if ($countones(got[i][16:14]) > 1 || (got[i][9] && got[i][6])) begin
                    fails++;
                    $display("FAIL dut%0d invariant t=%0t pc_strobes=%b w=%b stall=%b required=single-pc-strobe-and-no-w-in-stall",
                             i, $time, got[i][16:14], got[i][9], got[i][6]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        rnd_mode = 1'b0;
        for (int i = 0; i < NI; i++) begin
            opc[i] = OP_NOP; afl[i] = 4'h0; inv[i] = 1'b0; icnt[i] = 0; pidx[i] = 0;
            nxt[i] = rst_state(); ms[i] = rst_state();
        end
        repeat (3) step(1'b1);

        new_prog();
        prog.push_back(mk(OP_SUB,   4'b0010, 0));
        prog.push_back(mk(OP_BEQ,   4'b0000, 0));
        prog.push_back(mk(OP_SUB,   4'b0000, 0));
        prog.push_back(mk(OP_BEQ,   4'b1111, 0));
        prog.push_back(mk(OP_BNE,   4'b0000, 0));
        prog.push_back(mk(OP_ADDI,  4'b0100, 0));
        prog.push_back(mk(OP_BGE,   4'b0000, 0));
        prog.push_back(mk(OP_BLO,   4'b0000, 0));
        prog.push_back(mk(OP_SUBI,  4'b0001, 0));
        prog.push_back(mk(OP_BLO,   4'b0000, 0));
        prog.push_back(mk(OP_MULTI, 4'b1000, 0));
        prog.push_back(mk(OP_BGE,   4'b0000, 0));
        prog.push_back(mk(OP_JUMP,  4'b0111, 0));
        prog.push_back(mk(OP_LOAD,  4'b0101, 0));
        prog.push_back(mk(OP_NOP,   4'b0000, 0));
        prog.push_back(mk(OP_IN,    4'b0110, 4));
        prog.push_back(mk(OP_IN,    4'b0000, 0));
        prog.push_back(mk(OP_LOAD,  4'b0000, 0));
        prog.push_back(mk(OP_ADD,   4'b0011, 0));
        prog.push_back(mk(OP_BEQ,   4'b0000, 0));
        prog.push_back(mk(6'h2A,    4'b1111, 0));
        for (int k = 0; k < 10; k++) prog.push_back(mk(legal_op(k), 4'($urandom), 1));
        prog.push_back(mk(OP_HALT,  4'b0000, 0));
        for (int k = 0; k < 20; k++) prog.push_back(rnd_instr());
        drain();

        repeat (2) step(1'b1);
        new_prog();
        prog.push_back(mk(OP_LOAD, 4'b0000, 0));
        prog.push_back(mk(OP_ADD,  4'b1010, 0));
        prog.push_back(mk(OP_BEQ,  4'b0000, 0));
        step(1'b0);
        step(1'b0);
        step(1'b1);
        drain();

        new_prog();
        rnd_mode = 1'b1;
        for (int k = 0; k < 10000; k++)
            step((k % 300 == 299) || ($urandom_range(0, 499) == 0));
        rnd_mode = 1'b0;
        repeat (2) step(1'b0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
